buffer_packer: RTL and testbench
================================

Name: buffer_packer

Overview:
- Write-side counterpart of the coefficient buffer muxer: accepts a stream of polynomial coefficients one per handshake and packs them LSB-first into 64-bit memory words for write-back.
- Coefficients are 13-bit (mod 2^13) or 10-bit (mod 2^10, ten_bit_coeff mode).
- Sits between the multiplier result path and the data-memory write port.
- Emits exactly 52 words (13-bit mode) or 40 words (10-bit mode) per 256-coefficient polynomial, with no padding.

Parameters:
- COEFF_W, 13, full coefficient width.
- WORD_W, 64, memory word width.
- N_COEFF, 256, coefficients per polynomial.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_coeff  input  13  coefficient; only bits [9:0] are used in 10-bit mode.
- in_valid  input  1  in_coeff valid.
- in_ready  output  1  block can accept in_coeff this cycle.
- ten_bit_coeff  input  1  1 = 10-bit packing, 0 = 13-bit packing.
- out_word  output  64  packed word, registered.
- out_valid  output  1  out_word valid.
- out_ready  input  1  downstream accepts out_word.
- poly_done  output  1  one-cycle pulse when the last word of a polynomial is accepted.

Behaviour:
- Reset (async, rst=1): the following are cleared to 0: accumulator, fill count, coeff count, word count, out_valid, out_word, poly_done, latched mode. in_ready=1 after reset.
- Accumulator: 77-bit shift register acc with fill count f (0..76).
  - Stream bit order: coefficient k occupies stream bits [k*W+W-1 : k*W], with W=13 or 10.
  - Word w = stream bits [64w+63 : 64w].
- Output:
  - out_valid = (f >= 64).
  - out_word = acc[63:0].
  - out fire = out_valid & out_ready: acc shifts right 64 and f -= 64.
- Input:
  - in_ready = (f < 64) | out_ready. The combinational path from out_ready is allowed.
  - in fire = in_valid & in_ready: coefficient bits are written at acc[f + W - 1 : f] and f += W.
  - When both fires occur in the same cycle, the shift is applied first and the insert is made at position f-64. Resulting f = f - 64 + W.
- Sustained throughput: 1 coefficient per cycle when out_ready is held at 1.
- Mode latching:
  - ten_bit_coeff is sampled on the first in fire of each polynomial (coeff count = 0).
  - Changes to ten_bit_coeff mid-polynomial are ignored until the next polynomial.
  - W is taken from the latched mode, except on the first fire, which uses the live input.
- Counters:
  - Coeff count runs 0..255 and wraps to 0 after the 256th fire.
  - Word count runs 0..51 (13-bit) or 0..39 (10-bit).
- poly_done:
  - Registered pulse asserted the cycle after the out fire of the final word (word 51 or 39).
  - Word count resets to 0 at that point.
  - f is then exactly 0; no residue carries across polynomials.
- Masking: in 10-bit mode in_coeff[12:10] is ignored (masked to 0 in acc).
- Stability: out_word and out_valid hold stable while out_valid=1 and out_ready=0.
- in_valid=0: acc and f are unchanged. Gaps in the input stream are allowed anywhere.
- Reset mid-polynomial discards all partial state. The next coefficient is treated as coefficient 0 of a new polynomial.

Test Plan:
- 13-bit packing: mode 0, out_ready=1, feed 1,2,3,4,5 then 0x0000 → first out_word = 0x0050_0200_0C00_4001, valid in the cycle after the 5th fire makes f=65.
- 10-bit full polynomial: mode 1, 256 coefficients of 0x3FF with in_coeff[12:10]=3'b111 → exactly 40 words of 0xFFFF_FFFF_FFFF_FFFF, high bits never leak, poly_done pulses once after word 39, f=0 afterwards.
- 13-bit full polynomial: 256 coefficients k&0x1FFF → 52 words whose concatenation equals the reference bitstream, poly_done once after word 51.
- Backpressure: out_ready=0 for 10 cycles mid-stream → in_ready drops once f >= 64, out_word held constant, no coefficient lost or duplicated after release.
- Mode change mid-polynomial: toggle ten_bit_coeff at coefficient 100 → packing stays in the latched mode for all 256 coefficients. The next polynomial uses the new mode.
- Async reset after 30 coefficients → outputs go to 0 immediately. A subsequent full polynomial produces the correct 52 words and a single poly_done.

Source files
------------

// File: rtl/buffer_packer.sv
// buffer_packer: packs a stream of 13-bit or 10-bit polynomial coefficients
// LSB-first into 64-bit memory words for write-back. One polynomial of
// N_COEFF coefficients yields exactly 52 (13-bit) or 40 (10-bit) words.
module buffer_packer #(
  parameter int COEFF_W = 13,
  parameter int WORD_W  = 64,
  parameter int N_COEFF = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COEFF_W-1:0] in_coeff,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               ten_bit_coeff,
  output logic [WORD_W-1:0]  out_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               poly_done
);

  localparam int SHORT_W    = 10;
  localparam int ACC_W      = WORD_W + COEFF_W;
  localparam int FILL_W     = $clog2(ACC_W + 1);
  localparam int CNT_W      = $clog2(N_COEFF);
  localparam int LAST_LONG  = N_COEFF * COEFF_W / WORD_W - 1;
  localparam int LAST_SHORT = N_COEFF * SHORT_W / WORD_W - 1;
  localparam int WCNT_W     = $clog2(LAST_LONG + 1);

  localparam logic [COEFF_W-1:0] SHORT_MASK = COEFF_W'((1 << SHORT_W) - 1);

  logic [ACC_W-1:0]   acc, acc_next;
  logic [FILL_W-1:0]  fill, fill_next;
  logic [CNT_W-1:0]   coeff_cnt;
  logic [WCNT_W-1:0]  word_cnt;
  logic               mode_q;

  logic               in_fire, out_fire;
  logic               cur_ten;
  logic [FILL_W-1:0]  cur_w;
  logic [COEFF_W-1:0] coeff_masked;
  logic [WCNT_W-1:0]  word_last;
  logic               last_word;

  assign out_valid = (fill >= FILL_W'(WORD_W));
  assign out_word  = acc[WORD_W-1:0];
  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // The first coefficient of a polynomial takes its width from the live mode input.
  assign cur_ten      = (coeff_cnt == '0) ? ten_bit_coeff : mode_q;
  assign cur_w        = cur_ten ? FILL_W'(SHORT_W) : FILL_W'(COEFF_W);
  assign coeff_masked = cur_ten ? (in_coeff & SHORT_MASK) : in_coeff;

  assign word_last = mode_q ? WCNT_W'(LAST_SHORT) : WCNT_W'(LAST_LONG);
  assign last_word = (word_cnt == word_last);

  // Next accumulator/fill: drain a word first, then append at the post-drain fill.
  // Bits above the fill point are always zero, so the insert is a plain OR.
  always_comb begin
    acc_next  = acc;
    fill_next = fill;
    if (out_fire) begin
      acc_next  = acc >> WORD_W;
      fill_next = fill - FILL_W'(WORD_W);
    end
    if (in_fire) begin
      acc_next  = acc_next | (ACC_W'(coeff_masked) << fill_next);
      fill_next = fill_next + cur_w;
    end
  end

  // State registers: accumulator, counters, latched mode and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      fill      <= '0;
      coeff_cnt <= '0;
      word_cnt  <= '0;
      mode_q    <= 1'b0;
      poly_done <= 1'b0;
    end else begin
      acc       <= acc_next;
      fill      <= fill_next;
      poly_done <= out_fire && last_word;
      if (in_fire) begin
        if (coeff_cnt == '0)
          mode_q <= ten_bit_coeff;
        coeff_cnt <= (coeff_cnt == CNT_W'(N_COEFF - 1)) ? '0 : coeff_cnt + 1'b1;
      end
      if (out_fire)
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_buffer_packer.sv
// Self-checking bench for buffer_packer: a bit-queue reference model of the
// packed stream is compared against the DUT on every cycle, plus directed
// literal expectations.
module tb_buffer_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] in_coeff = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ten_bit_coeff = 1'b0;
  logic [63:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        poly_done;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          mq[$];
  int          m_cc = 0;
  int          m_wc = 0;
  bit          m_mode = 0;
  bit          m_done = 0;
  bit          m_in_fire = 0;

  // DUT observations
  logic [63:0] dut_words[$];
  int          dut_done_cnt = 0;
  int          stall_seen = 0;

  buffer_packer #(.COEFF_W(13), .WORD_W(64), .N_COEFF(256)) dut (
    .clk(clk), .rst(rst), .in_coeff(in_coeff), .in_valid(in_valid),
    .in_ready(in_ready), .ten_bit_coeff(ten_bit_coeff), .out_word(out_word),
    .out_valid(out_valid), .out_ready(out_ready), .poly_done(poly_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: the stream is a queue of bits; words leave from the front.
  always @(posedge clk or posedge rst) begin
    bit v, rdy, of, ten;
    int w;
    if (rst) begin
      mq.delete();
      m_cc = 0; m_wc = 0; m_mode = 0; m_done = 0; m_in_fire = 0;
    end else begin
      v   = (mq.size() >= 64);
      rdy = !v || out_ready;
      of  = v && out_ready;
      m_in_fire = in_valid && rdy;
      m_done = 0;
      if (of) begin
        repeat (64) void'(mq.pop_front());
        m_wc++;
        if (m_wc == (m_mode ? 40 : 52)) begin
          m_done = 1;
          m_wc = 0;
        end
      end
      if (m_in_fire) begin
        ten = (m_cc == 0) ? ten_bit_coeff : m_mode;
        if (m_cc == 0) m_mode = ten_bit_coeff;
        w = ten ? 10 : 13;
        for (int j = 0; j < w; j++) mq.push_back(in_coeff[j]);
        m_cc = (m_cc + 1) % 256;
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    logic [63:0] ew;
    bit ev;
    if (!rst) begin
      ev = (mq.size() >= 64);
      check("out_valid", {63'd0, out_valid}, {63'd0, ev});
      check("in_ready", {63'd0, in_ready}, {63'd0, (!ev || out_ready)});
      check("poly_done", {63'd0, poly_done}, {63'd0, m_done});
      if (ev) begin
        for (int j = 0; j < 64; j++) ew[j] = mq[j];
        check("out_word", out_word, ew);
      end
      if (out_valid && out_ready) dut_words.push_back(out_word);
      if (poly_done) dut_done_cnt++;
      if (!in_ready) stall_seen++;
    end
  end

  task automatic clear_capture();
    dut_words.delete();
    dut_done_cnt = 0;
    stall_seen = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // kind: 0 random 13-bit, 1 all-ones 13-bit, 2 index value
  task automatic drive_poly(input int n, input int kind, input bit mode, input int vprob,
                            input int rprob, input int toggle_at, input int stall_at);
    int stall = 0;
    for (int i = 0; i < n; i++) begin
      int tries = 0;
      bit done = 0;
      in_coeff = (kind == 0) ? 13'($urandom) : (kind == 1) ? 13'h1FFF : 13'(i);
      ten_bit_coeff = (i >= toggle_at) ? !mode : mode;
      while (!done) begin
        if (i == stall_at && tries == 0) stall = 10;
        in_valid = ($urandom_range(99) < vprob);
        if (stall > 0) begin
          out_ready = 1'b0;
          in_valid = 1'b1;
          stall--;
        end else begin
          out_ready = ($urandom_range(99) < rprob);
        end
        @(posedge clk); #1;
        done = m_in_fire;
        tries++;
        if (!done && tries > 2000) begin
          check("coeff_accept_timeout", 64'd0, 64'd1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_poly(input int exp_words);
    int cyc = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (mq.size() != 0 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (mq.size() != 0) check("drain_timeout", 64'd0, 64'd1);
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    @(negedge clk); #1;
    check("residue_valid", {63'd0, out_valid}, 64'd0);
    check("residue_ready", {63'd0, in_ready}, 64'd1);
    check("residue_word", out_word, 64'd0);
    check("word_count", 64'(dut_words.size()), 64'(exp_words));
    check("done_count", 64'(dut_done_cnt), 64'd1);
  endtask

  initial begin
    logic [63:0] w;
    int s;
    bit rmode;

    // reset state
    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_word", out_word, 64'd0);
    check("rst_poly_done", {63'd0, poly_done}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    do_reset();

    // 13-bit first word literal
    @(posedge clk); #1;
    ten_bit_coeff = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_coeff = 13'(i);
      @(posedge clk); #1;
    end
    in_coeff = '0;
    @(negedge clk);
    check("first_word_valid", {63'd0, out_valid}, 64'd1);
    check("first_word", out_word, 64'h0050_0200_0C00_4001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    do_reset();

    // 10-bit full polynomial, high bits must be masked
    clear_capture();
    drive_poly(256, 1, 1'b1, 100, 100, 1000, -1);
    finish_poly(40);
    for (int i = 0; i < dut_words.size(); i++)
      check("ten_bit_word", dut_words[i], 64'hFFFF_FFFF_FFFF_FFFF);

    // 13-bit full polynomial against an independently built bitstream
    clear_capture();
    drive_poly(256, 2, 1'b0, 100, 100, 1000, -1);
    finish_poly(52);
    for (int wi = 0; wi < 52 && wi < dut_words.size(); wi++) begin
      for (int b = 0; b < 64; b++) begin
        s = wi * 64 + b;
        w[b] = (((s / 13) & 13'h1FFF) >> (s % 13)) & 1;
      end
      check("stream_word", dut_words[wi], w);
    end

    // backpressure mid-stream
    clear_capture();
    drive_poly(256, 0, 1'b0, 100, 100, 1000, 120);
    finish_poly(52);
    check("stall_in_ready_dropped", {63'd0, (stall_seen > 0)}, 64'd1);

    // mode toggle mid-polynomial is ignored; the next polynomial uses it
    clear_capture();
    drive_poly(256, 2, 1'b0, 100, 100, 100, -1);
    finish_poly(52);
    clear_capture();
    drive_poly(256, 0, 1'b1, 100, 100, 1000, -1);
    finish_poly(40);

    // async reset mid-polynomial
    clear_capture();
    drive_poly(30, 0, 1'b0, 100, 100, 1000, -1);
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", {63'd0, out_valid}, 64'd0);
    check("async_out_word", out_word, 64'd0);
    check("async_poly_done", {63'd0, poly_done}, 64'd0);
    check("async_in_ready", {63'd0, in_ready}, 64'd1);
    do_reset();
    clear_capture();
    drive_poly(256, 0, 1'b0, 100, 100, 1000, -1);
    finish_poly(52);

    // randomized polynomials with gaps, backpressure and mode toggles
    for (int p = 0; p < 4; p++) begin
      rmode = $urandom_range(1);
      clear_capture();
      drive_poly(256, 0, rmode, 60, 50, int'($urandom_range(300)), int'($urandom_range(255)));
      finish_poly(rmode ? 40 : 52);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
